// File: rtl/rst_sync_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
// State encoding is also driven out on SEQ_STATE for debug visibility.
`timescale 1ns/1ps
package rst_sync_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'b00,
    ST_HOLD    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_DONE    = 2'b11
  } seq_state_e;

  // One counter is shared by the hold and gap phases, so it is sized for the longer one.
  function automatic int cnt_width(input int hold, input int gap);
    int longest;
    longest = (hold > gap) ? hold : gap;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rst_sync_seq_if.sv
// Sequenced-reset bundle between the sequencer (master) and the sub-blocks it resets (slave).
// SW_RST_REQ exists only when RST_SYNC_SEQ_SW_RST_EN is defined.
`timescale 1ns/1ps
interface rst_sync_seq_if #(
  parameter int NUM_OUTS = 3
);
  import rst_sync_pkg::*;

  logic [NUM_OUTS-1:0] SYNC_RST;
  logic                RST_DONE;
  seq_state_e          SEQ_STATE;
`ifdef RST_SYNC_SEQ_SW_RST_EN
  logic                SW_RST_REQ;

  modport master (
    output SYNC_RST, RST_DONE, SEQ_STATE,
    input  SW_RST_REQ
  );
  modport slave (
    input  SYNC_RST, RST_DONE, SEQ_STATE,
    output SW_RST_REQ
  );
`else
  modport master (
    output SYNC_RST, RST_DONE, SEQ_STATE
  );
  modport slave (
    input  SYNC_RST, RST_DONE, SEQ_STATE
  );
`endif

endinterface

// File: rtl/rst_sync_seq_chain.sv
// Plain async-clear synchronizer for the RST deassertion edge.
// Cleared instantly by RST low; a 1 walks in from the MSB and reaches sync_n NUM_STAGES edges later.
`timescale 1ns/1ps
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_n
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("rst_sync_chain: NUM_STAGES must be >= 2 (got %0d)", NUM_STAGES);
  end

  logic [NUM_STAGES-1:0] chain;

  // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chain <= '0;
    else      chain <= {1'b1, chain[NUM_STAGES-1:1]};
  end

  assign sync_n = chain[0];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset synchronizer + ordered release sequencer: asserts all SYNC_RST bits asynchronously on RST,
// then releases bit 0..NUM_OUTS-1 synchronously. Optional soft reset via RST_SYNC_SEQ_SW_RST_EN.
`timescale 1ns/1ps
module rst_sync_seq
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int NUM_OUTS   = 3,
  parameter int MIN_HOLD   = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  rst_sync_seq_if.master     bus
);

  if (NUM_OUTS < 1 || NUM_OUTS > 16) begin : g_bad_outs
    $error("rst_sync_seq: NUM_OUTS must be 1..16 (got %0d)", NUM_OUTS);
  end
  if (MIN_HOLD < 1) begin : g_bad_hold
    $error("rst_sync_seq: MIN_HOLD must be >= 1 (got %0d)", MIN_HOLD);
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("rst_sync_seq: GAP_CYCLES must be >= 1 (got %0d)", GAP_CYCLES);
  end

  localparam int CW = cnt_width(MIN_HOLD, GAP_CYCLES);
  localparam int IW = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTS - 1);

  logic                sync_n;
  logic                sw_req;

  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [IW-1:0]       idx_q,   idx_d;
  logic [NUM_OUTS-1:0] sync_q,  sync_d;
  logic                done_q,  done_d;

  rst_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_chain (
    .CLK    (CLK),
    .RST    (RST),
    .sync_n (sync_n)
  );

`ifdef RST_SYNC_SEQ_SW_RST_EN
  assign sw_req = bus.SW_RST_REQ;
`else
  assign sw_req = 1'b0;
`endif

  // Every piece of sequencer state, outputs included, is cleared the moment RST falls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      sync_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every next value and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sync_d  = sync_q;
    done_d  = done_q;

    unique case (state_q)
      ST_RESET: begin
        if (sync_n) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          sync_d[0] = 1'b1;
          cnt_d     = '0;
          idx_d     = IW'(1);
          if (NUM_OUTS == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          sync_d[idx_q] = 1'b1;
          cnt_d         = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        sync_d = '1;
        done_d = 1'b1;
      end
    endcase

    // A soft request wins over the normal sequence, restarts the hold and pins cnt at 0 while it stays high.
    if (sw_req && state_q != ST_RESET) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      sync_d  = '0;
      done_d  = 1'b0;
    end
  end

  assign bus.SYNC_RST  = sync_q;
  assign bus.RST_DONE  = done_q;
  assign bus.SEQ_STATE = state_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Scoreboard bench for rst_sync_seq: a default instance and a NUM_OUTS=1/MIN_HOLD=1/NUM_STAGES=3 instance.
// Soft-reset scenarios are compiled only with RST_SYNC_SEQ_SW_RST_EN.
`timescale 1ns/1ps
module tb_rst_sync_seq;
  import rst_sync_pkg::*;

  localparam int NS1 = 2, NO1 = 3, MH1 = 8, GP1 = 4;
  localparam int NS2 = 3, NO2 = 1, MH2 = 1, GP2 = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rst_sync_seq_if #(.NUM_OUTS(NO1)) bus1();
  rst_sync_seq_if #(.NUM_OUTS(NO2)) bus2();

  rst_sync_seq #(.NUM_STAGES(NS1), .NUM_OUTS(NO1), .MIN_HOLD(MH1), .GAP_CYCLES(GP1))
    dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  rst_sync_seq #(.NUM_STAGES(NS2), .NUM_OUTS(NO2), .MIN_HOLD(MH2), .GAP_CYCLES(GP2))
    dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  // Edge 1 is the first CLK edge after RST rises.
  int edge_no;
  always @(posedge CLK or negedge RST) begin
    if (!RST) edge_no <= 0;
    else      edge_no <= edge_no + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct { int edge_no; logic [15:0] sync; logic done; } out_exp_t;
  typedef struct { int edge_no; logic [1:0] st; } st_exp_t;

  out_exp_t q1_out[$], q2_out[$];
  st_exp_t  q1_st[$],  q2_st[$];

  logic [16:0] prev1_out, prev2_out, cur1, cur2;
  logic [1:0]  prev1_st,  prev2_st;
  out_exp_t    eo;
  st_exp_t     es;

  // Every output change is popped against the scoreboard at the negedge after it happens.
  always @(negedge CLK) begin
    cur1 = {bus1.RST_DONE, 16'(bus1.SYNC_RST)};
    cur2 = {bus2.RST_DONE, 16'(bus2.SYNC_RST)};
    if (!RST) begin
      prev1_out = cur1; prev1_st = bus1.SEQ_STATE;
      prev2_out = cur2; prev2_st = bus2.SEQ_STATE;
    end else begin
      if (cur1 !== prev1_out) begin
        if (q1_out.size() == 0) check("d1_out_unexpected", cur1, prev1_out);
        else begin
          eo = q1_out.pop_front();
          check("d1_out_edge", edge_no, eo.edge_no);
          check("d1_out_value", cur1, {eo.done, eo.sync});
        end
        prev1_out = cur1;
      end
      if (bus1.SEQ_STATE !== prev1_st) begin
        if (q1_st.size() == 0) check("d1_state_unexpected", bus1.SEQ_STATE, prev1_st);
        else begin
          es = q1_st.pop_front();
          check("d1_state_edge", edge_no, es.edge_no);
          check("d1_state_value", bus1.SEQ_STATE, es.st);
        end
        prev1_st = bus1.SEQ_STATE;
      end
      if (cur2 !== prev2_out) begin
        if (q2_out.size() == 0) check("d2_out_unexpected", cur2, prev2_out);
        else begin
          eo = q2_out.pop_front();
          check("d2_out_edge", edge_no, eo.edge_no);
          check("d2_out_value", cur2, {eo.done, eo.sync});
        end
        prev2_out = cur2;
      end
      if (bus2.SEQ_STATE !== prev2_st) begin
        if (q2_st.size() == 0) check("d2_state_unexpected", bus2.SEQ_STATE, prev2_st);
        else begin
          es = q2_st.pop_front();
          check("d2_state_edge", edge_no, es.edge_no);
          check("d2_state_value", bus2.SEQ_STATE, es.st);
        end
        prev2_st = bus2.SEQ_STATE;
      end
    end
  end

  // Bit 0 rises at 'first'; bit i follows at first + i*GAP, RST_DONE with the last bit.
  task automatic push_seq(input int d, input int first);
    int no, gp;
    out_exp_t e;
    no = (d == 1) ? NO1 : NO2;
    gp = (d == 1) ? GP1 : GP2;
    for (int i = 0; i < no; i++) begin
      e.edge_no = first + i * gp;
      e.sync    = 16'((32'd1 << (i + 1)) - 1);
      e.done    = (i == no - 1);
      if (d == 1) q1_out.push_back(e); else q2_out.push_back(e);
    end
    if (no > 1) begin
      if (d == 1) q1_st.push_back('{edge_no: first, st: ST_RELEASE});
      else        q2_st.push_back('{edge_no: first, st: ST_RELEASE});
    end
    if (d == 1) q1_st.push_back('{edge_no: first + (no - 1) * gp, st: ST_DONE});
    else        q2_st.push_back('{edge_no: first + (no - 1) * gp, st: ST_DONE});
  endtask

  task automatic release_rst(input int phase);
    @(posedge CLK);
    #(phase);
    RST = 1'b1;
    q1_st.push_back('{edge_no: NS1 + 1, st: ST_HOLD});
    q2_st.push_back('{edge_no: NS2 + 1, st: ST_HOLD});
    push_seq(1, NS1 + MH1 + 1);
    push_seq(2, NS2 + MH2 + 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sync1"},  32'(bus1.SYNC_RST),  0);
    check({tag, "_done1"},  32'(bus1.RST_DONE),  0);
    check({tag, "_state1"}, 32'(bus1.SEQ_STATE), 32'(ST_RESET));
    check({tag, "_sync2"},  32'(bus2.SYNC_RST),  0);
    check({tag, "_done2"},  32'(bus2.RST_DONE),  0);
    check({tag, "_state2"}, 32'(bus2.SEQ_STATE), 32'(ST_RESET));
  endtask

  task automatic check_done(input string tag);
    check({tag, "_sync1"},    32'(bus1.SYNC_RST),  32'((1 << NO1) - 1));
    check({tag, "_done1"},    32'(bus1.RST_DONE),  1);
    check({tag, "_state1"},   32'(bus1.SEQ_STATE), 32'(ST_DONE));
    check({tag, "_sync2"},    32'(bus2.SYNC_RST),  32'((1 << NO2) - 1));
    check({tag, "_done2"},    32'(bus2.RST_DONE),  1);
    check({tag, "_pending1"}, q1_out.size() + q1_st.size(), 0);
    check({tag, "_pending2"}, q2_out.size() + q2_st.size(), 0);
  endtask

  // Assert RST between edges; outputs must clear with no clock edge in between.
  task automatic async_rst(input string tag);
    RST = 1'b0;
    #1;
    check_idle(tag);
    q1_out.delete(); q1_st.delete(); q2_out.delete(); q2_st.delete();
    repeat (3) @(posedge CLK);
  endtask

  // Bounded wait until edge n has happened; lands 2 time units after that edge.
  task automatic wait_edge(input int n);
    for (int i = 0; i < 200; i++) begin
      if (edge_no >= n) break;
      @(posedge CLK);
      #2;
    end
    check("wait_edge", edge_no, n);
  endtask

`ifdef RST_SYNC_SEQ_SW_RST_EN
  task automatic flush_future1();
    while (q1_out.size() > 0 && q1_out[$].edge_no > edge_no) void'(q1_out.pop_back());
    while (q1_st.size()  > 0 && q1_st[$].edge_no  > edge_no) void'(q1_st.pop_back());
  endtask
`endif

  int phases [4] = '{1, 4, 6, 9};

  initial begin
`ifdef RST_SYNC_SEQ_SW_RST_EN
    bus1.SW_RST_REQ = 1'b0;
    bus2.SW_RST_REQ = 1'b0;
`endif
    // Power-up: RST low for 5 cycles, then the full release sequence.
    repeat (5) @(posedge CLK);
    #2;
    check_idle("por");
    release_rst(5);
    wait_edge(22);
    check_done("t1");

    // Mid-sequence RST between edges 16 and 17, then a clean restart.
    async_rst("t2_pre");
    release_rst(3);
    wait_edge(16);
    async_rst("t2_mid");
    release_rst(3);
    wait_edge(22);
    check_done("t2");

    // RST deassertion swept across clock phases.
    for (int k = 0; k < 4; k++) begin
      async_rst("t6");
      release_rst(phases[k]);
      wait_edge(22);
      check_done("t6");
    end

`ifdef RST_SYNC_SEQ_SW_RST_EN
    begin
      int n0;
      // Soft reset from DONE, request held for 3 edges (last one L = n0+3).
      n0 = edge_no;
      bus1.SW_RST_REQ = 1'b1;
      flush_future1();
      q1_out.push_back('{edge_no: n0 + 1, sync: 16'd0, done: 1'b0});
      q1_st.push_back('{edge_no: n0 + 1, st: ST_HOLD});
      wait_edge(n0 + 3);
      bus1.SW_RST_REQ = 1'b0;
      push_seq(1, n0 + 3 + MH1);
      wait_edge(n0 + 3 + MH1 + (NO1 - 1) * GP1 + 2);
      check_done("t4");
    end

    // Request ignored in RESET, honoured in RELEASE.
    async_rst("t5");
    release_rst(3);
    bus1.SW_RST_REQ = 1'b1;
    wait_edge(2);
    bus1.SW_RST_REQ = 1'b0;
    wait_edge(13);
    check("t5_state_release", 32'(bus1.SEQ_STATE), 32'(ST_RELEASE));
    bus1.SW_RST_REQ = 1'b1;
    flush_future1();
    q1_out.push_back('{edge_no: 14, sync: 16'd0, done: 1'b0});
    q1_st.push_back('{edge_no: 14, st: ST_HOLD});
    wait_edge(14);
    bus1.SW_RST_REQ = 1'b0;
    push_seq(1, 14 + MH1);
    wait_edge(14 + MH1 + (NO1 - 1) * GP1 + 2);
    check_done("t5");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
